// File: rtl/aesl_deadlock_pkg.sv
// Shared types and helpers for the deadlock monitor: FSM states, child-combining modes
// and the width of a stream index that also encodes "no stream" as N.
package aesl_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  localparam int SUB_PARALLEL = 0;
  localparam int SUB_SINGLE   = 1;
  localparam int SUB_NONE     = 2;

  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/aesl_deadlock_cause_enc.sv
// Lowest-set-bit priority encoder; purely combinational.
// Reports N when no bit is set so callers can tell "no stream" from stream 0.
module aesl_deadlock_cause_enc
  import aesl_deadlock_pkg::*;
#(
  parameter int N = 14
) (
  input  logic [N-1:0]               bits,
  output logic [idx_width(N)-1:0]    idx
);

  localparam int IW = idx_width(N);

  always_comb begin
    idx = IW'(N);
    // Walk downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (bits[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/aesl_deadlock_monitor_gen2.sv
// Deadlock monitor: raw block condition must persist THRESHOLD cycles before `block` rises;
// reports the lowest masked stalled stream and a saturating stall length.
module aesl_deadlock_monitor_gen2
  import aesl_deadlock_pkg::*;
#(
  parameter int                  NUM_AXIS  = 14,
  parameter logic [NUM_AXIS-1:0] AXIS_MASK = 14'h3FF0,
  parameter int                  NUM_SUB   = 3,
  parameter int                  SUB_MODE  = 0,
  parameter int                  THRESHOLD = 16,
  parameter bit                  STICKY    = 1'b0,
  parameter int                  CNT_W     = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_AXIS-1:0]           axis_block_sigs,
  input  logic [NUM_SUB-1:0]            inst_idle_sigs,
  input  logic [NUM_SUB-1:0]            inst_block_sigs,
  input  logic                          clear,
  output logic                          block,
  output logic                          pending,
  output logic [idx_width(NUM_AXIS)-1:0] blocked_idx,
  output logic [CNT_W-1:0]              blocked_cycles
);

  localparam int IW = idx_width(NUM_AXIS);
  localparam int CW = $clog2(THRESHOLD + 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [NUM_AXIS-1:0] axis_masked;
  logic [NUM_SUB-1:0]  act;
  logic            axis_hit, sub_hit, raw;
  logic [IW-1:0]   cause_idx;

  assign axis_masked = axis_block_sigs & AXIS_MASK;
  assign axis_hit    = |axis_masked;
  assign act         = ~inst_idle_sigs;

  always_comb begin
    sub_hit = 1'b0;
    if (SUB_MODE == SUB_PARALLEL)
      sub_hit = (|act) & (&(inst_block_sigs | inst_idle_sigs));
    else if (SUB_MODE == SUB_SINGLE)
      sub_hit = |(inst_block_sigs & act);
  end

  assign raw = axis_hit | sub_hit;

  aesl_deadlock_cause_enc #(.N(NUM_AXIS)) u_cause_enc (
    .bits (axis_masked),
    .idx  (cause_idx)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (clear) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: if (raw) begin
          state_nxt = (THRESHOLD == 1) ? ST_BLOCKED : ST_SUSPECT;
          cnt_nxt   = CW'(1);
        end
        ST_SUSPECT: begin
          if (!raw) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else if (int'(cnt) + 1 == THRESHOLD) begin
            state_nxt = ST_BLOCKED;
            cnt_nxt   = CW'(THRESHOLD);
          end else begin
            cnt_nxt   = cnt + CW'(1);
          end
        end
        ST_BLOCKED: if (!raw && !STICKY) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      blocked_idx    <= '0;
      blocked_cycles <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Cause is frozen at the entry edge; the count saturates rather than wrapping.
      if (state_nxt == ST_BLOCKED && state != ST_BLOCKED) begin
        blocked_idx    <= cause_idx;
        blocked_cycles <= CNT_W'(1);
      end else if (state_nxt == ST_BLOCKED) begin
        if (blocked_cycles != '1) blocked_cycles <= blocked_cycles + CNT_W'(1);
      end else begin
        blocked_idx    <= '0;
        blocked_cycles <= '0;
      end
    end
  end

  assign block   = (state == ST_BLOCKED);
  assign pending = (state == ST_SUSPECT);

endmodule
